// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, frame width and the oversample divisor
// used by both the receive and transmit enables.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] STOP    = 3'd3;
  localparam logic [2:0] WAIT_HI = 3'd4;

  // Truncated clocks-per-oversample-tick, never below one.
  function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
    int d;
    d = clk_hz / (baud * ovs);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, received byte and status strobes out.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  modport master (input rx, output data, data_valid, frame_err, busy);
  modport slave  (output rx, input data, data_valid, frame_err, busy);
endinterface

// File: rtl/uart_os_tick.sv
// Free-running oversample enable: a one-clock tick every DIV system clocks.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600,
  parameter int OVS    = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVS);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, qualifies the start bit at mid-bit and
// samples each data and stop bit at mid-bit on the oversample tick.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600,
  parameter int OVS    = 16
) (
  input logic         clk,
  input logic         reset,
  uart_rx_if.master   bus
);

  localparam int SW = $clog2(OVS);

  logic [1:0]           sync;
  logic                 rx_s;
  logic                 tick;
  logic [2:0]           state;
  logic [SW-1:0]        scnt;
  logic [2:0]           bcnt;
  logic [DATA_BITS-1:0] sreg;
  logic [DATA_BITS-1:0] data_q;
  logic                 data_valid_q;
  logic                 frame_err_q;

  uart_os_tick #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Resets to the idle-line level so a reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], bus.rx};
  end

  assign rx_s = sync[1];

  // WAIT_HI is the only state that reacts between ticks, so a break ends promptly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      scnt         <= '0;
      bcnt         <= '0;
      sreg         <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (tick && !rx_s) begin
            state <= START;
            scnt  <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (scnt == SW'(OVS / 2 - 1)) begin
              scnt <= '0;
              bcnt <= '0;
              state <= rx_s ? IDLE : DATA;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (scnt == SW'(OVS - 1)) begin
              sreg <= {rx_s, sreg[DATA_BITS-1:1]};
              scnt <= '0;
              bcnt <= bcnt + 1'b1;
              if (bcnt == 3'd7) state <= STOP;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (scnt == SW'(OVS - 1)) begin
              scnt <= '0;
              if (rx_s) begin
                data_q       <= sreg;
                data_valid_q <= 1'b1;
                state        <= IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state       <= WAIT_HI;
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
        WAIT_HI: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state != IDLE);

endmodule
